// File: rtl/spi_loader.sv
// SPI slave loader: synchronises the SPI pins, frames cmd/addr/data bits LSB first,
// and turns completed write frames into one-cycle cache write strobes plus a MISO read-back.
module spi_loader #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              csi_n_in,
  input  logic              csd_n_in,
  input  logic              mosi_in,
  input  logic              busy_in,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              icache_wen_out,
  output logic              dcache_wen_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              miso_out,
  output logic              frame_err_out,
  output logic              active_out
);
  localparam int TOT = 1 + ADDR_W + DATA_W;
  localparam logic [3:0] CNT_TOT  = 4'(TOT);
  localparam logic [3:0] CNT_ADDR = 4'(ADDR_W);
  localparam logic [3:0] CNT_HDR  = 4'(1 + ADDR_W);
  localparam int P_SCLK = 0, P_CSI = 1, P_CSD = 2, P_MOSI = 3;
  localparam logic [3:0] PIN_IDLE = 4'b0110;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, ERR} state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]        lvl_q;
  logic              sclk_rise, sclk_fall;
  state_t            state;
  logic [3:0]        bit_cnt;
  logic [TOT-1:0]    frame, frame_nx;
  logic              sel_d, ready, rd_load;
  logic [DATA_W-1:0] tx, tx_sh;
  logic              csi_l, csd_l, mosi_l, both_low, one_low, sel_high;

  // Pin synchronisers; lvl_q is the edge-detect stage, so events and levels line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{PIN_IDLE}};
      lvl_q     <= PIN_IDLE;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sync_q[0] <= {mosi_in, csd_n_in, csi_n_in, sclk_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      lvl_q     <= sync_q[SYNC_STAGES-1];
      sclk_rise <= sync_q[SYNC_STAGES-1][P_SCLK] & ~lvl_q[P_SCLK];
      sclk_fall <= ~sync_q[SYNC_STAGES-1][P_SCLK] & lvl_q[P_SCLK];
    end
  end

  assign csi_l    = lvl_q[P_CSI];
  assign csd_l    = lvl_q[P_CSD];
  assign mosi_l   = lvl_q[P_MOSI];
  assign both_low = ~csi_l & ~csd_l;
  assign one_low  = csi_l ^ csd_l;
  assign sel_high = sel_d ? csd_l : csi_l;
  assign tx_sh    = tx >> 1;
  assign active_out = (state != IDLE);

  always_comb begin
    frame_nx = frame;
    for (int i = 0; i < TOT; i++)
      if (sclk_rise && i == int'(bit_cnt)) frame_nx[i] = mosi_l;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      frame          <= '0;
      sel_d          <= 1'b0;
      ready          <= 1'b0;
      rd_load        <= 1'b0;
      tx             <= '0;
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      addr_out       <= '0;
      data_out       <= '0;
      miso_out       <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      rd_load        <= 1'b0;
      if (state inside {CMD, ADDR, WDATA, RDATA} && sclk_rise) begin
        frame <= frame_nx;
        if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
      end
      // The fall that closes the last address bit must not shift: bit 0 is presented first.
      if (rd_load) begin
        tx       <= rd_data_in;
        miso_out <= rd_data_in[0];
      end else if (state == RDATA && sclk_fall && bit_cnt > CNT_HDR) begin
        tx       <= tx_sh;
        miso_out <= tx_sh[0];
      end
      unique case (state)
        IDLE: begin
          // A fresh frame needs both selects seen high first (e.g. after a mid-frame reset).
          if (both_low) begin
            state         <= ERR;
            frame_err_out <= 1'b1;
            ready         <= 1'b0;
          end else if (!one_low) begin
            ready <= 1'b1;
          end else if (ready) begin
            ready         <= 1'b0;
            sel_d         <= csi_l;
            bit_cnt       <= '0;
            frame         <= '0;
            frame_err_out <= busy_in;
            state         <= busy_in ? ERR : CMD;
          end
        end
        CMD, ADDR, WDATA, RDATA: begin
          if (both_low) begin
            state         <= ERR;
            frame_err_out <= 1'b1;
          end else if (sel_high) begin
            state <= IDLE;
            if (state == WDATA) begin
              if (bit_cnt == CNT_TOT && !busy_in) begin
                icache_wen_out <= ~sel_d;
                dcache_wen_out <= sel_d;
                addr_out       <= frame[ADDR_W:1];
                data_out       <= frame[TOT-1:ADDR_W+1];
              end else begin
                frame_err_out <= 1'b1;
              end
            end else if (state != RDATA) begin
              frame_err_out <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (state == CMD) begin
              state <= ADDR;
            end else if (state == ADDR && bit_cnt == CNT_ADDR) begin
              if (frame_nx[0]) begin
                state <= WDATA;
              end else begin
                state    <= RDATA;
                addr_out <= frame_nx[ADDR_W:1];
                rd_load  <= 1'b1;
              end
            end
          end
        end
        ERR: if (csi_l && csd_l) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_loader.sv
// Directed plus randomised frames for spi_loader, checked against a frame-level model
// with its own copy of both cache memories.
module tb_spi_loader;
  logic clk = 1'b0;
  logic rst, sclk_in, csi_n_in, csd_n_in, mosi_in, busy_in;
  logic [7:0] rd_data_in;
  logic icache_wen_out, dcache_wen_out, miso_out, frame_err_out, active_out;
  logic [3:0] addr_out;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  spi_loader #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .csi_n_in(csi_n_in), .csd_n_in(csd_n_in),
    .mosi_in(mosi_in), .busy_in(busy_in), .rd_data_in(rd_data_in),
    .icache_wen_out(icache_wen_out), .dcache_wen_out(dcache_wen_out),
    .addr_out(addr_out), .data_out(data_out), .miso_out(miso_out),
    .frame_err_out(frame_err_out), .active_out(active_out)
  );

  // Caches written only by the DUT strobes; the model keeps its own copies.
  logic [7:0] imem [16];
  logic [7:0] dmem [16];
  bit   [7:0] m_imem [16];
  bit   [7:0] m_dmem [16];
  logic rd_sel = 1'b0;
  always @(posedge clk) begin
    if (icache_wen_out) imem[addr_out] <= data_out;
    if (dcache_wen_out) dmem[addr_out] <= data_out;
  end
  assign rd_data_in = rd_sel ? dmem[addr_out] : imem[addr_out];

  int icnt = 0, dcnt = 0;
  logic [3:0] last_a = '0;
  logic [7:0] last_d = '0;
  always @(negedge clk) begin
    if (icache_wen_out) begin icnt <= icnt + 1; last_a <= addr_out; last_d <= data_out; end
    if (dcache_wen_out) begin dcnt <= dcnt + 1; last_a <= addr_out; last_d <= data_out; end
  end

  int ncmp = 0, nerr = 0;
  logic [7:0] last_miso;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mosi_in = b; tick(4); sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
  endtask

  // fb: [0]=cmd, [4:1]=addr, [12:5]=data, [15:13]=overrun bits.
  task automatic do_frame(input string tag, input bit ci, input bit cd, input int n,
                          input logic [15:0] fb, input bit busy);
    int i0, d0;
    logic w3, w4;
    logic [7:0] mw, mask, mem_v;
    bit both, wr, err;
    i0 = icnt; d0 = dcnt; mw = '0;
    rd_sel = cd; busy_in = busy; csi_n_in = !ci; csd_n_in = !cd;
    tick(4);
    for (int k = 0; k < n; k++) begin
      mosi_in = fb[k];
      tick(4);
      if (k >= 5 && k < 13) mw[k-5] = miso_out;
      sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
    end
    tick(4);
    csi_n_in = 1'b1; csd_n_in = 1'b1;
    tick(3); w3 = cd ? dcache_wen_out : icache_wen_out;
    tick(1); w4 = cd ? dcache_wen_out : icache_wen_out;
    tick(4);
    busy_in = 1'b0;
    last_miso = mw;
    both = ci && cd;
    wr   = !both && !busy && fb[0] && n == 13;
    err  = both || busy || (fb[0] && n != 13);
    chk({tag, "_err"}, 32'(frame_err_out), 32'(err));
    chk({tag, "_iwen"}, 32'(icnt - i0), 32'(wr && ci));
    chk({tag, "_dwen"}, 32'(dcnt - d0), 32'(wr && cd));
    if (wr) begin
      chk({tag, "_lat3"}, 32'(w3), 32'(0));
      chk({tag, "_lat4"}, 32'(w4), 32'(1));
      chk({tag, "_waddr"}, 32'(last_a), 32'(fb[4:1]));
      chk({tag, "_wdata"}, 32'(last_d), 32'(fb[12:5]));
      if (ci) m_imem[fb[4:1]] = fb[12:5]; else m_dmem[fb[4:1]] = fb[12:5];
    end
    if (!fb[0] && !both && !busy) begin
      chk({tag, "_raddr"}, 32'(addr_out), 32'(fb[4:1]));
      if (n > 5) begin
        mem_v = cd ? m_dmem[fb[4:1]] : m_imem[fb[4:1]];
        mask  = (n >= 13) ? 8'hFF : 8'((1 << (n - 5)) - 1);
        chk({tag, "_miso"}, 32'(mw & mask), 32'(mem_v & mask));
      end
    end
  endtask

  initial begin
    int r, n;
    bit ci, cd, busy;
    logic [15:0] fb;
    int i0, d0;
    rst = 1'b1; sclk_in = 1'b0; csi_n_in = 1'b1; csd_n_in = 1'b1; mosi_in = 1'b0; busy_in = 1'b0;
    tick(3);
    chk("rst_iwen", 32'(icache_wen_out), 32'(0));
    chk("rst_dwen", 32'(dcache_wen_out), 32'(0));
    chk("rst_addr", 32'(addr_out), 32'(0));
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_miso", 32'(miso_out), 32'(0));
    chk("rst_err", 32'(frame_err_out), 32'(0));
    chk("rst_active", 32'(active_out), 32'(0));
    rst = 1'b0;
    tick(4);

    do_frame("wr_i5", 1, 0, 13, {3'b000, 8'hA7, 4'h5, 1'b1}, 0);
    chk("wr_i5_addr", 32'(addr_out), 32'h5);
    chk("wr_i5_data", 32'(data_out), 32'hA7);

    do_frame("short", 0, 1, 10, {3'b000, 8'h55, 4'h3, 1'b1}, 0);
    chk("short_flag", 32'(frame_err_out), 32'(1));
    do_frame("wr_d9", 0, 1, 13, {3'b000, 8'hB4, 4'h9, 1'b1}, 0);
    chk("wr_d9_clr", 32'(frame_err_out), 32'(0));

    do_frame("both", 1, 1, 13, {3'b000, 8'h66, 4'h1, 1'b1}, 0);
    chk("both_flag", 32'(frame_err_out), 32'(1));
    do_frame("busy", 1, 0, 13, {3'b000, 8'h3C, 4'h2, 1'b1}, 1);
    chk("busy_flag", 32'(frame_err_out), 32'(1));

    do_frame("rd_d9", 0, 1, 13, {3'b000, 8'h00, 4'h9, 1'b0}, 0);
    chk("rd_d9_addr", 32'(addr_out), 32'h9);
    chk("rd_d9_bits", 32'(last_miso), 32'hB4);

    // Reset after 7 bits of a write; the rest of the frame must be ignored.
    i0 = icnt; d0 = dcnt;
    csi_n_in = 1'b0; tick(4);
    chk("mid_active", 32'(active_out), 32'(1));
    fb = {3'b000, 8'hE1, 4'h6, 1'b1};
    for (int k = 0; k < 7; k++) send_bit(fb[k]);
    rst = 1'b1; tick(2);
    chk("mid_rst_addr", 32'(addr_out), 32'(0));
    chk("mid_rst_data", 32'(data_out), 32'(0));
    chk("mid_rst_active", 32'(active_out), 32'(0));
    chk("mid_rst_err", 32'(frame_err_out), 32'(0));
    rst = 1'b0;
    for (int k = 7; k < 13; k++) send_bit(fb[k]);
    tick(4); csi_n_in = 1'b1; tick(8);
    chk("mid_no_wen", 32'((icnt - i0) + (dcnt - d0)), 32'(0));
    chk("mid_active2", 32'(active_out), 32'(0));
    chk("mid_err2", 32'(frame_err_out), 32'(0));

    for (int a = 0; a < 16; a++) begin
      do_frame("fill_i", 1, 0, 13, {3'b000, 8'($urandom), 4'(a), 1'b1}, 0);
      do_frame("fill_d", 0, 1, 13, {3'b000, 8'($urandom), 4'(a), 1'b1}, 0);
    end

    for (int t = 0; t < 40; t++) begin
      r    = $urandom_range(0, 9);
      ci   = (r == 0) || (r % 2 == 1);
      cd   = (r == 0) || (r % 2 == 0);
      busy = ($urandom_range(0, 9) == 0);
      fb   = 16'($urandom);
      if (fb[0]) n = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 15) : 13;
      else       n = $urandom_range(5, 13);
      do_frame("rand", ci, cd, n, fb, busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
